// File: rtl/sv_latch_share_arbiter.sv
// Round-robin owner of one shared external data latch: captures the winner's data
// for one cycle, holds ownership for HOLD_CYCLES, and services a global clear.
module sv_latch_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         latch_en,
    output logic                         latch_clr,
    output logic [WIDTH-1:0]             latch_din,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         owner_valid,
    output logic                         busy
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HOLD, S_CLEAR} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  hold_cnt;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;

    // Scan from ptr upward, wrapping, and take the first active request.
    always_comb begin
        win   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            ack         <= '0;
            latch_en    <= 1'b0;
            latch_clr   <= 1'b0;
            latch_din   <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ack       <= '0;
            latch_en  <= 1'b0;
            latch_clr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        state       <= S_CLEAR;
                        latch_clr   <= 1'b1;
                        grant       <= '0;
                        owner_valid <= 1'b0;
                        busy        <= 1'b1;
                    end else if (|req) begin
                        state     <= S_CAPTURE;
                        grant     <= NUM_REQ'(1) << win;
                        latch_din <= req_data[int'(win)*WIDTH +: WIDTH];
                        latch_en  <= 1'b1;
                        owner     <= win;
                        ptr       <= IDW'((int'(win) + 1) % NUM_REQ);
                        busy      <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (clear) begin
                        state       <= S_CLEAR;
                        latch_clr   <= 1'b1;
                        grant       <= '0;
                        owner_valid <= 1'b0;
                    end else begin
                        state       <= S_HOLD;
                        ack         <= grant;
                        owner_valid <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                S_HOLD: begin
                    // Ownership lasts the full hold window regardless of req.
                    if (clear) begin
                        state       <= S_CLEAR;
                        latch_clr   <= 1'b1;
                        grant       <= '0;
                        owner_valid <= 1'b0;
                    end else if (hold_cnt == CW'(HOLD_CYCLES - 1)) begin
                        state <= S_IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_CLEAR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sv_latch_share_arbiter.sv
// Bench for sv_latch_share_arbiter: directed scenarios then random traffic, all
// compared each cycle against a timeline model of ownership plus an external latch.
module tb_sv_latch_share_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     grant;
    logic [N-1:0]     ack;
    logic             latch_en;
    logic             latch_clr;
    logic [W-1:0]     latch_din;
    logic [1:0]       owner;
    logic             owner_valid;
    logic             busy;
    logic [W-1:0]     latch_q;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 capture, 2..H+1 hold slots, -1 clear.
    int           m_phase;
    int           m_w;
    int           m_ptr;
    int           m_owner;
    logic         m_valid;
    logic [W-1:0] m_din;
    logic [W-1:0] m_lat;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] din_q[$];

    sv_latch_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(reset), .clear(clear), .req(req), .req_data(req_data),
        .grant(grant), .ack(ack), .latch_en(latch_en), .latch_clr(latch_clr),
        .latch_din(latch_din), .owner(owner), .owner_valid(owner_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the external registered latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          latch_q <= '0;
        else if (latch_clr) latch_q <= '0;
        else if (latch_en)  latch_q <= latch_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_w = 0; m_ptr = 0; m_owner = 0;
        m_valid = 1'b0; m_din = '0; m_lat = '0;
    endtask

    task automatic model_edge(input logic c, input logic [N-1:0] r, input logic [N*W-1:0] d);
        if (m_phase == -1) m_lat = '0;
        else if (m_phase == 1) m_lat = m_din;
        if (m_phase == 0) begin
            if (c) begin
                m_phase = -1; m_valid = 1'b0;
            end else if (r != 0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (r[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
                m_phase = 1;
                m_owner = m_w;
                m_din   = d[m_w*W +: W];
                m_ptr   = (m_w + 1) % N;
            end
        end else if (m_phase == -1) begin
            m_phase = 0;
        end else if (c) begin
            m_phase = -1; m_valid = 1'b0;
        end else begin
            if (m_phase == 1) m_valid = 1'b1;
            m_phase = (m_phase == H + 1) ? 0 : m_phase + 1;
        end
    endtask

    task automatic check_all();
        logic [31:0] eg;
        eg = (m_phase >= 1) ? 32'(1 << m_w) : 32'd0;
        chk("grant", 32'(grant), eg);
        chk("ack", 32'(ack), (m_phase == 2) ? eg : 32'd0);
        chk("latch_en", 32'(latch_en), 32'(m_phase == 1));
        chk("latch_clr", 32'(latch_clr), 32'(m_phase == -1));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("latch_din", 32'(latch_din), 32'(m_din));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("owner_valid", 32'(owner_valid), 32'(m_valid));
        chk("latch_q", 32'(latch_q), 32'(m_lat));
        chk("en_clr_excl", 32'(latch_en & latch_clr), 32'd0);
        chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    endtask

    task automatic step(input logic c, input logic [N-1:0] r, input logic [N*W-1:0] d);
        clear = c; req = r; req_data = d;
        @(posedge clk);
        model_edge(c, r, d);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_latch_en", 32'(latch_en), 32'd0);
        chk("rst_owner_valid", 32'(owner_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [N*W-1:0] rr_data;
        int busy_cycles;
        int last_cap;

        reset = 1'b1; clear = 1'b0; req = '0; req_data = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Single requester 1 with data 0x55.
        busy_cycles = 0;
        step(1'b0, 4'b0010, 32'h0000_5500);
        chk("single_grant", 32'(grant), 32'h2);
        chk("single_din", 32'(latch_din), 32'h55);
        busy_cycles += int'(busy);
        step(1'b0, 4'b0000, 32'h0);
        chk("single_ack", 32'(ack), 32'h2);
        chk("single_owner", 32'(owner), 32'd1);
        chk("single_latch", 32'(latch_q), 32'h55);
        busy_cycles += int'(busy);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0000, 32'h0);
            busy_cycles += int'(busy);
        end
        chk("single_busy_len", 32'(busy_cycles), 32'd5);

        // Async reset in the middle of HOLD, then ptr must restart at 0.
        step(1'b0, 4'b1111, 32'h0403_0201);
        step(1'b0, 4'b1111, 32'h0403_0201);
        step(1'b0, 4'b1111, 32'h0403_0201);
        async_reset();

        // Round robin with all requesting.
        rr_data = 32'h4030_2010;
        exp_q = '{8'h1, 8'h2, 8'h4, 8'h8, 8'h1};
        din_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
        last_cap = -6;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 4'b1111, rr_data);
            if (latch_en === 1'b1 && exp_q.size() > 0) begin
                chk("rr_grant", 32'(grant), 32'(exp_q.pop_front()));
                chk("rr_din", 32'(latch_din), 32'(din_q.pop_front()));
                chk("rr_period", 32'(i - last_cap), 32'd6);
                last_cap = i;
            end
        end
        chk("rr_all_seen", 32'(exp_q.size()), 32'd0);

        // Clear on the second HOLD cycle.
        step(1'b0, 4'b1111, rr_data);
        step(1'b0, 4'b0000, rr_data);
        step(1'b0, 4'b0000, rr_data);
        step(1'b1, 4'b0000, rr_data);
        chk("hclr_clr", 32'(latch_clr), 32'd1);
        chk("hclr_grant", 32'(grant), 32'd0);
        chk("hclr_valid", 32'(owner_valid), 32'd0);
        step(1'b0, 4'b0000, rr_data);
        chk("hclr_idle", 32'(busy), 32'd0);
        chk("hclr_latch", 32'(latch_q), 32'h00);

        // Clear and request together in IDLE: clear wins.
        step(1'b1, 4'b0001, 32'h0000_00a5);
        chk("cr_grant0", 32'(grant), 32'd0);
        step(1'b0, 4'b0001, 32'h0000_00a5);
        step(1'b0, 4'b0001, 32'h0000_00a5);
        chk("cr_grant", 32'(grant), 32'h1);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 32'h0);

        // Wrap past the top index, then clear during CAPTURE.
        async_reset();
        step(1'b0, 4'b0100, 32'h0033_0000);
        chk("wrap_g2", 32'(grant), 32'h4);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 32'h0);
        step(1'b0, 4'b0101, 32'h0011_0022);
        chk("wrap_g0", 32'(grant), 32'h1);
        step(1'b1, 4'b0000, 32'h0);
        chk("capclr_ack", 32'(ack), 32'd0);
        step(1'b0, 4'b0000, 32'h0);
        chk("capclr_ack2", 32'(ack), 32'd0);
        step(1'b0, 4'b1111, 32'h4433_2211);
        chk("wrap_ptr1", 32'(grant), 32'h2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom_range(0, 15));
            step($urandom_range(0, 9) == 0, r, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
